// File: rtl/muldiv_pkg.sv
// Shared funct codes, FSM state encoding and request classifiers for the
// HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_hilo_access(input logic [5:0] f);
        return (f == FUNCT_MFHI) || (f == FUNCT_MTHI) ||
               (f == FUNCT_MFLO) || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-facing request/result bundle of the multiply/divide sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (output req_valid, funct, rs_data, rt_data,
                    input  stall, busy, done, hi, lo, mf_data);
    modport slave  (input  req_valid, funct, rs_data, rt_data,
                    output stall, busy, done, hi, lo, mf_data);
endinterface

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: one shift-add multiply step or one restoring divide
// step per enabled cycle on a 2*WIDTH accumulator.
module muldiv_iter_dp #(parameter int WIDTH = 32) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   load_acc,
    input  logic [WIDTH-1:0]   load_op,
    output logic [2*WIDTH-1:0] acc
);
    logic [WIDTH-1:0]   op;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_ext;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, op};
        // Partial remainder after the left shift needs one extra bit.
        rem_ext  = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_ext - {1'b0, op};
        acc_next = acc;
        if (div_mode)
            acc_next = diff[WIDTH] ? {rem_ext[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
        else if (acc[0])
            acc_next = {add_sum, acc[WIDTH-1:1]};
        else
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            op  <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, load_acc};
            op  <= load_op;
        end else if (step) begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: FSM, iteration counter, sign handling, pipeline stall and
// MT/MF access around the iterative multiply/divide datapath.
module muldiv_sequencer import muldiv_pkg::*; #(parameter int WIDTH = 32) (
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               neg_q, neg_r, op_is_div, div_zero;
    logic               accept, is_signed, op_div, rt_zero, sgn_rs, sgn_rt, last_iter;
    logic [WIDTH-1:0]   abs_rs, abs_rt, load_acc, load_op, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] acc, prod;

    always_comb begin
        accept    = bus.req_valid && (state == IDLE) && is_muldiv(bus.funct);
        is_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
        op_div    = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
        rt_zero   = (bus.rt_data == '0);
        sgn_rs    = is_signed & bus.rs_data[WIDTH-1];
        sgn_rt    = is_signed & bus.rt_data[WIDTH-1];
        abs_rs    = sgn_rs ? -bus.rs_data : bus.rs_data;
        abs_rt    = sgn_rt ? -bus.rt_data : bus.rt_data;
        // Divide-by-zero parks raw rs in the accumulator so FIX can return it as HI.
        load_acc  = op_div ? (rt_zero ? bus.rs_data : abs_rs) : abs_rt;
        load_op   = op_div ? abs_rt : abs_rs;
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = op_div ? (rt_zero ? FIX : DIV) : MUL;
            MUL,
            DIV:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prod   = neg_q ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_zero) begin
            fix_hi = acc[WIDTH-1:0];
            fix_lo = '1;
        end else if (op_is_div) begin
            fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            op_is_div <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == FIX);
            if (accept) begin
                cnt       <= '0;
                neg_q     <= sgn_rs ^ sgn_rt;
                neg_r     <= sgn_rs;
                op_is_div <= op_div;
                div_zero  <= op_div & rt_zero;
            end else if ((state == MUL) || (state == DIV)) begin
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (bus.req_valid && (state == IDLE)) begin
                if (bus.funct == FUNCT_MTHI) hi_q <= bus.rs_data;
                if (bus.funct == FUNCT_MTLO) lo_q <= bus.rs_data;
            end
        end
    end

    muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     ((state == MUL) || (state == DIV)),
        .div_mode (state == DIV),
        .load_acc (load_acc),
        .load_op  (load_op),
        .acc      (acc)
    );

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.stall   = bus.req_valid & busy_q &
                         (is_muldiv(bus.funct) | is_hilo_access(bus.funct));
    assign bus.mf_data = (bus.funct == FUNCT_MFHI) ? hi_q :
                         (bus.funct == FUNCT_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected HI/LO queued at issue and
// compared after the done pulse, plus stall, MT/MF and reset-abort checks.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    res_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus();
    muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid = v;
        bus.funct     = f;
        bus.rs_data   = a;
        bus.rt_data   = b;
        #1;
    endtask

    task automatic do_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input int lat);
        res_t r;
        int   n;
        int   busy_bad;
        logic seen;
        drive(1'b1, f, a, b);
        check({tag, " accept_stall"}, bus.stall, 0);
        sbq.push_back('{exp_hi, exp_lo});
        tick;
        drive(1'b0, 6'h0, '0, '0);
        n = 1; busy_bad = 0; seen = 1'b0;
        while (n < 100) begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick;
            n++;
        end
        check({tag, " done_seen"}, seen, 1);
        check({tag, " latency"}, n, lat);
        check({tag, " busy_span"}, busy_bad, 0);
        tick;
        r = sbq.pop_front();
        check({tag, " hi"}, bus.hi, r.hi);
        check({tag, " lo"}, bus.lo, r.lo);
        check({tag, " idle_busy"}, bus.busy, 0);
        check({tag, " done_pulse"}, bus.done, 0);
    endtask

    initial begin
        res_t r;
        int   dones;
        logic [W-1:0] a, b;
        logic [63:0]  p;
        int   sa, sv;
        longint sp;

        drive(1'b0, 6'h0, '0, '0);
        tick; tick;
        rst = 1'b0;
        drive(1'b0, FUNCT_MFHI, '0, '0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst hi", bus.hi, 0);
        check("rst lo", bus.lo, 0);
        check("rst mf_data", bus.mf_data, 0);
        tick;

        do_op("mult_neg",   FUNCT_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, W + 1);
        do_op("multu_max",  FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, W + 1);
        do_op("div_neg",    FUNCT_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, W + 1);
        do_op("divu_zero",  FUNCT_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1);
        do_op("div_zero_s", FUNCT_DIV,   32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1);
        do_op("div_ovf",    FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, W + 1);

        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            p = {32'h0, a} * {32'h0, b};
            do_op("multu_rnd", FUNCT_MULTU, a, b, p[63:32], p[31:0], W + 1);
            sa = $signed($urandom);
            sv = $signed($urandom_range(1, 5000));
            if ($urandom_range(0, 1) == 1) sv = -sv;
            sp = longint'(sa) * longint'(sv);
            do_op("mult_rnd", FUNCT_MULT, sa, sv, sp[63:32], sp[31:0], W + 1);
            b = $urandom_range(1, 70000);
            do_op("divu_rnd", FUNCT_DIVU, a, b, a % b, a / b, W + 1);
            do_op("div_rnd", FUNCT_DIV, sa, sv, sa % sv, sa / sv, W + 1);
        end

        // Dependent requests during a multiply must stall and never latch.
        drive(1'b1, FUNCT_MULT, 32'd5, 32'd6);
        check("stall accept", bus.stall, 0);
        sbq.push_back('{32'd0, 32'd30});
        tick;
        for (int i = 1; i <= W + 1; i++) begin
            drive(1'b1, (i == 3) ? FUNCT_MULT : (i == 5) ? FUNCT_MTHI :
                        (i == 7) ? FUNCT_MTLO : FUNCT_MFLO, 32'hDEAD, 32'd3);
            check("stall busy", bus.stall, 1);
            tick;
        end
        drive(1'b1, FUNCT_MFLO, 32'hDEAD, 32'd3);
        r = sbq.pop_front();
        check("stall release", bus.stall, 0);
        check("mflo after mult", bus.mf_data, r.lo);
        check("hi after mult", bus.hi, r.hi);
        check("busy at release", bus.busy, 0);
        tick;
        drive(1'b0, 6'h0, '0, '0);
        check("no relaunch", bus.busy, 0);
        check("lo kept", bus.lo, 30);

        drive(1'b1, FUNCT_MTHI, 32'h12345678, '0);
        check("mthi stall", bus.stall, 0);
        tick;
        drive(1'b1, FUNCT_MFHI, '0, '0);
        check("mfhi data", bus.mf_data, 32'h12345678);
        check("mfhi stall", bus.stall, 0);
        check("mt busy", bus.busy, 0);
        tick;
        drive(1'b1, FUNCT_MTLO, 32'hCAFEF00D, '0);
        tick;
        drive(1'b1, FUNCT_MFLO, '0, '0);
        check("mflo data", bus.mf_data, 32'hCAFEF00D);
        tick;
        drive(1'b1, 6'h20, 32'h55555555, 32'd1);
        check("unknown stall", bus.stall, 0);
        check("unknown mf_data", bus.mf_data, 0);
        tick;
        drive(1'b0, 6'h0, '0, '0);
        check("unknown busy", bus.busy, 0);
        check("unknown hi", bus.hi, 32'h12345678);
        check("unknown lo", bus.lo, 32'hCAFEF00D);

        // Abort a multiply at iteration 10.
        drive(1'b1, FUNCT_MTHI, 32'hAAAA, '0);
        tick;
        drive(1'b1, FUNCT_MTLO, 32'hAAAA, '0);
        tick;
        drive(1'b1, FUNCT_MULT, 32'd3, 32'd3);
        tick;
        drive(1'b0, 6'h0, '0, '0);
        for (int i = 0; i < 10; i++) tick;
        check("pre-abort hi", bus.hi, 32'hAAAA);
        check("pre-abort busy", bus.busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort busy", bus.busy, 0);
        check("abort hi", bus.hi, 0);
        check("abort lo", bus.lo, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dones++;
            tick;
        end
        check("abort no done", dones, 0);
        check("abort still idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
